// File: rtl/hex_display_driver.sv
// hex_display_driver
//   Converts the 16-bit PIO seven-segment word into six active-low HEX digit
//   drives.
//   - Hex mode shows four nibbles, a blank position and an 'H'.
//   - Decimal mode runs a 16-cycle double-dabble conversion, shows five BCD
//     digits and a 'd'.
//   All six outputs are written together when a conversion completes.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous, active-low reset
//   value      16-bit word to display (synchronous to clk)
//   mode_dec   1 = decimal, 0 = hexadecimal
//   blank_lz   1 = blank leading zero digits (hex0 always shown)
//   hex0..hex5 segment drives, bit0 = seg a .. bit6 = seg g, active-low
//   busy       high while a conversion is in flight
module hex_display_driver (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        mode_dec,
  input  logic        blank_lz,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_D     = 7'h21;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t      state;
  state_t      state_next;
  logic        force_start;
  logic [3:0]  iter;
  logic        start;

  // Shadow copy of the inputs taken at start. sh_value doubles as the binary
  // half of the double-dabble register: it is rotated rather than shifted, so
  // after 16 iterations it holds the original word again and change detection
  // in IDLE still compares against what was converted.
  logic [15:0] sh_value;
  logic        sh_dec;
  logic        sh_blank;
  logic [19:0] bcd;

  logic [3:0]  dig [5];
  logic [6:0]  seg [6];
  logic        lead_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct each BCD nibble >= 5, then shift in the
  // next binary bit (MSB first).
  function automatic logic [19:0] dabble(input logic [19:0] acc, input logic bit_in);
    logic [19:0] adj;
    adj = acc;
    for (int n = 0; n < 5; n++) begin
      if (adj[4*n +: 4] >= 4'd5) adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
    end
    return {adj[18:0], bit_in};
  endfunction

  assign start = force_start || (value != sh_value) ||
                 (mode_dec != sh_dec) || (blank_lz != sh_blank);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = mode_dec ? CONVERT : UPDATE;
      CONVERT: if (iter == 4'd15) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control: state, forced-start flag, iteration count, visible outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      force_start <= 1'b1;
      iter        <= 4'd0;
      hex0        <= SEG_BLANK;
      hex1        <= SEG_BLANK;
      hex2        <= SEG_BLANK;
      hex3        <= SEG_BLANK;
      hex4        <= SEG_BLANK;
      hex5        <= SEG_BLANK;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        force_start <= 1'b0;
        iter        <= 4'd0;
      end else if (state == CONVERT) begin
        iter <= iter + 4'd1;
      end
      if (state == UPDATE) begin
        hex0 <= seg[0];
        hex1 <= seg[1];
        hex2 <= seg[2];
        hex3 <= seg[3];
        hex4 <= seg[4];
        hex5 <= seg[5];
      end
    end
  end

  // Datapath: snapshot at start, one dabble step per CONVERT cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sh_value <= value;
      sh_dec   <= mode_dec;
      sh_blank <= blank_lz;
      bcd      <= 20'd0;
    end else if (state == CONVERT) begin
      bcd      <= dabble(bcd, sh_value[15]);
      sh_value <= {sh_value[14:0], sh_value[15]};
    end
  end

  // Digit selection and leading-zero blanking, consumed in UPDATE
  always_comb begin
    dig[0] = sh_dec ? bcd[3:0]   : sh_value[3:0];
    dig[1] = sh_dec ? bcd[7:4]   : sh_value[7:4];
    dig[2] = sh_dec ? bcd[11:8]  : sh_value[11:8];
    dig[3] = sh_dec ? bcd[15:12] : sh_value[15:12];
    dig[4] = sh_dec ? bcd[19:16] : 4'd0;
    lead_zero = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (dig[i] != 4'd0) lead_zero = 1'b0;
      seg[i] = (sh_blank && lead_zero) ? SEG_BLANK : seg7(dig[i]);
    end
    seg[0] = seg7(dig[0]);
    if (!sh_dec) seg[4] = SEG_BLANK;
    seg[5] = sh_dec ? SEG_D : SEG_H;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hex_display_driver.sv
// tb_hex_display_driver
//   Directed and randomized stimulus for hex_display_driver, checked against
//   an arithmetic reference model of the displayed digits.
module tb_hex_display_driver;

  logic        clk;
  logic        reset_n;
  logic [15:0] value;
  logic        mode_dec;
  logic        blank_lz;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_driver dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .mode_dec (mode_dec),
    .blank_lz (blank_lz),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex4     (hex4),
    .hex5     (hex5),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] outs_now();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  // Reference: digits by division, blanking by magnitude (a position above
  // the units is blank when the number is smaller than that position's weight).
  function automatic logic [41:0] model(input logic [15:0] v, input logic dec, input logic blk);
    logic [6:0] e [6];
    int vi, base, nd, pw, d;
    vi = v;
    base = dec ? 10 : 16;
    nd   = dec ? 5 : 4;
    pw   = 1;
    for (int i = 0; i < 6; i++) e[i] = 7'h7F;
    for (int i = 0; i < nd; i++) begin
      d = (vi / pw) % base;
      if (blk && i > 0 && vi < pw) e[i] = 7'h7F;
      else e[i] = seg_tab[d];
      pw = pw * base;
    end
    e[5] = dec ? 7'h21 : 7'h09;
    return {e[5], e[4], e[3], e[2], e[1], e[0]};
  endfunction

  task automatic chk_outs(input string tag, input logic [41:0] exp);
    logic [41:0] o;
    o = outs_now();
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s hex%0d", tag, i), 32'(o[7*i +: 7]), 32'(exp[7*i +: 7]));
  endtask

  // Drive inputs, take the start edge, count busy cycles (bounded), confirm
  // outputs hold until the single update, then compare against the model.
  task automatic run(input logic [15:0] v, input logic d, input logic b, input string tag);
    logic [41:0] prev;
    int cyc;
    bit stable;
    prev = outs_now();
    value = v; mode_dec = d; blank_lz = b;
    tick();
    cyc = 0; stable = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (outs_now() !== prev) stable = 1'b0;
      tick();
    end
    chk({tag, " busy_cycles"}, cyc, d ? 17 : 1);
    chk({tag, " atomic"}, 32'(stable), 32'd1);
    chk_outs(tag, model(v, d, b));
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] lv, rv;
    logic        ld, lb, rd, rb;
    int          cyc;

    // Reset held with value 0, hex mode
    reset_n = 1'b0; value = 16'd0; mode_dec = 1'b0; blank_lz = 1'b0;
    tick(); tick();
    chk_outs("reset", {6{7'h7F}});
    chk("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    run(16'd0, 1'b0, 1'b0, "first");

    run(16'hBEEF, 1'b0, 1'b0, "hex_beef");
    run(16'h00A5, 1'b0, 1'b1, "hex_lz");
    run(16'd1234, 1'b1, 1'b1, "dec_1234");
    run(16'd65535, 1'b1, 1'b0, "dec_max");
    run(16'd0, 1'b1, 1'b1, "dec_zero");
    run(16'd0, 1'b0, 1'b1, "hex_zero");

    // Input change during conversion: first run still shows 100
    value = 16'd100; mode_dec = 1'b1; blank_lz = 1'b1;
    tick();
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 6) value = 16'd7;
      tick();
    end
    chk("chg busy_cycles", cyc, 17);
    chk_outs("chg first", model(16'd100, 1'b1, 1'b1));
    tick();
    chk("chg restart busy", 32'(busy), 32'd1);
    cyc = 1;
    tick();
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("chg second busy_cycles", cyc, 17);
    chk_outs("chg second", model(16'd7, 1'b1, 1'b1));

    // Reset in the middle of a conversion
    value = 16'd4321; mode_dec = 1'b1; blank_lz = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) tick();
    reset_n = 1'b0;
    #1;
    chk_outs("midrst", {6{7'h7F}});
    chk("midrst busy", 32'(busy), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    run(16'd4321, 1'b1, 1'b0, "reconv");

    // Randomized runs; each differs from the previous inputs so a start occurs
    lv = 16'd4321; ld = 1'b1; lb = 1'b0;
    for (int k = 0; k < 24; k++) begin
      rv = (k % 3 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      rd = 1'($urandom);
      rb = 1'($urandom);
      if (rv == lv && rd == ld && rb == lb) rv = rv ^ 16'd1;
      run(rv, rd, rb, $sformatf("rand%0d", k));
      lv = rv; ld = rd; lb = rb;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
